// File: rtl/uart_pkg.sv
// Shared types and constants for the MMIO UART transmitter.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 434;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO feeding the UART transmitter.
module uart_tx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     Rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_c;
    logic             do_pop_c;

    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push_c = push && !full;
    assign do_pop_c  = pop && !empty;
    assign dout      = mem_q[rd_ptr_q];
    assign count     = count_q;

    // Storage array; contents need no reset since occupancy gates reads.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (Rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_c) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_mmio_tx.sv
// MMIO store path to 8N1 serial transmitter with a decoupling FIFO.
module uart_mmio_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic                           clk,
    input  logic                           Rst,
    input  logic                           mmio_wea,
    input  logic [31:0]                    mmio_dat,
    output logic                           tx,
    output logic                           mmio_read,
    output logic                           tx_ready,
    output logic                           tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           overflow
);

    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

    uart_tx_state_t              state_q;
    logic [BAUD_W-1:0]           baud_q;
    logic [2:0]                  bit_idx_q;
    logic [UART_DATA_BITS-1:0]   shift_q;
    logic                        tx_q;
    logic                        stop_done_q;
    logic                        read_q;
    logic                        overflow_q;

    logic                        bit_end_c;
    logic                        fifo_push_c;
    logic                        fifo_pop_c;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [UART_DATA_BITS-1:0]   fifo_dout;
    logic                        unused_c;

    assign unused_c    = ^mmio_dat[31:8];
    assign bit_end_c   = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    assign fifo_push_c = mmio_wea && !fifo_full;
    assign fifo_pop_c  = !fifo_empty &&
                         ((state_q == IDLE) || ((state_q == STOP) && bit_end_c));

    assign tx        = tx_q;
    assign mmio_read = read_q;
    assign overflow  = overflow_q;
    assign tx_ready  = !fifo_full;
    assign tx_busy   = (state_q != IDLE) || !fifo_empty;

    uart_tx_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .Rst   (Rst),
        .push  (fifo_push_c),
        .pop   (fifo_pop_c),
        .din   (mmio_dat[UART_DATA_BITS-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Frame FSM; tx and the completion pulse are registered from the current
    // state, so the line lags the state by one cycle and the pulse lands one
    // cycle after the stop bit leaves the line.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q     <= IDLE;
            baud_q      <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            tx_q        <= 1'b1;
            stop_done_q <= 1'b0;
            read_q      <= 1'b0;
        end else begin
            read_q      <= stop_done_q;
            stop_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (!fifo_empty) begin
                        shift_q <= fifo_dout;
                        baud_q  <= '0;
                        state_q <= START;
                    end
                end
                START: begin
                    tx_q <= 1'b0;
                    if (bit_end_c) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    tx_q <= shift_q[0];
                    if (bit_end_c) begin
                        baud_q  <= '0;
                        shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
                        if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (bit_end_c) begin
                        baud_q      <= '0;
                        stop_done_q <= 1'b1;
                        if (!fifo_empty) begin
                            shift_q <= fifo_dout;
                            state_q <= START;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Sticky record of any store dropped against a full FIFO.
    always_ff @(posedge clk) begin
        if (Rst) begin
            overflow_q <= 1'b0;
        end else if (mmio_wea && fifo_full) begin
            overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_mmio_tx.sv
// Self-checking bench for uart_mmio_tx against a frame-schedule reference model.
module tb_uart_mmio_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * CPB;

    logic        clk = 1'b0;
    logic        Rst = 1'b1;
    logic        mmio_wea = 1'b0;
    logic [31:0] mmio_dat = '0;
    logic        tx;
    logic        mmio_read;
    logic        tx_ready;
    logic        tx_busy;
    logic [2:0]  fifo_count;
    logic        overflow;

    uart_mmio_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .Rst        (Rst),
        .mmio_wea   (mmio_wea),
        .mmio_dat   (mmio_dat),
        .tx         (tx),
        .mmio_read  (mmio_read),
        .tx_ready   (tx_ready),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int cyc    = 0;
    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: every accepted byte with its accept edge and the edge
    // after which its start bit appears on the line.
    int         m_edge[$];
    int         m_fall[$];
    logic [7:0] m_byte[$];
    logic       m_ovf = 1'b0;

    // Line monitor: a simple UART receiver plus pulse log.
    logic [7:0] rx_bytes[$];
    int         rx_falls[$];
    int         read_cyc[$];
    bit         rx_active = 1'b0;
    int         rx_start = 0;
    int         rx_bit = 0;
    logic [7:0] rx_sh = '0;
    int         rx_bad_stop = 0;

    // Expected {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} after edge t.
    function automatic logic [7:0] exp_vec(input int t);
        logic etx;
        logic erd;
        logic ebusy;
        int   cnt;
        etx = 1'b1; erd = 1'b0; ebusy = 1'b0; cnt = 0;
        foreach (m_fall[j]) begin
            int f;
            int b;
            f = m_fall[j];
            if (t >= f && t < f + FRAME) begin
                b = (t - f) / CPB;
                if (b == 0)      etx = 1'b0;
                else if (b == 9) etx = 1'b1;
                else             etx = m_byte[j][b-1];
            end
            if (t == f + FRAME) erd = 1'b1;
            if (t >= f - 1 && t <= f + FRAME - 2) ebusy = 1'b1;
            if (m_edge[j] <= t && f - 1 > t) cnt++;
        end
        if (cnt > 0) ebusy = 1'b1;
        return {etx, erd, (cnt < DEPTH), ebusy, m_ovf, 3'(cnt)};
    endfunction

    // Drive one cycle, update the model for the coming edge, then sample.
    task automatic step(input bit we, input logic [31:0] d, input bit rst);
        int e;
        int occ;
        e = cyc + 1;
        mmio_wea = we;
        mmio_dat = d;
        Rst      = rst;
        if (rst) begin
            m_edge.delete(); m_fall.delete(); m_byte.delete(); m_ovf = 1'b0;
            rx_bytes.delete(); rx_falls.delete(); read_cyc.delete();
            rx_active = 1'b0; rx_bad_stop = 0;
        end else if (we) begin
            occ = 0;
            foreach (m_fall[j]) if (m_fall[j] - 1 >= e) occ++;
            if (occ >= DEPTH) begin
                m_ovf = 1'b1;
            end else begin
                m_edge.push_back(e);
                m_byte.push_back(d[7:0]);
                if (m_fall.size() == 0 || m_fall[$] + FRAME < e + 2) m_fall.push_back(e + 2);
                else m_fall.push_back(m_fall[$] + FRAME);
            end
        end
        @(posedge clk);
        cyc = e;
        @(negedge clk);
        mmio_wea = 1'b0;
        if (mmio_read === 1'b1) read_cyc.push_back(cyc);
        if (rx_active) begin
            if (cyc == rx_start + CPB * rx_bit + 1) begin
                if (rx_bit >= 1 && rx_bit <= 8) rx_sh[rx_bit-1] = tx;
                if (rx_bit == 9) begin
                    if (tx !== 1'b1) rx_bad_stop++;
                    rx_bytes.push_back(rx_sh);
                    rx_active = 1'b0;
                end
                rx_bit++;
            end
        end else if (tx === 1'b0) begin
            rx_active = 1'b1;
            rx_start  = cyc;
            rx_bit    = 0;
            rx_falls.push_back(cyc);
        end
    endtask

    task automatic test_reset();
        step(0, '0, 1);
        step(0, '0, 1);
        n_cmp++;
        if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== 8'b1_0_1_0_0_000) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, 8'b10100000);
        end
        repeat (50) begin
            step(0, '0, 0);
            n_cmp++;
            if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== exp_vec(cyc)) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, exp_vec(cyc));
            end
        end
        n_cmp++;
        if (read_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL reset_no_read pulses=%0d exp=0", read_cyc.size());
        end
    endtask

    task automatic test_single_frame(input logic [31:0] d, input bit do_reset, input string name);
        int k;
        if (do_reset) begin
            step(0, '0, 1);
            step(0, '0, 1);
        end
        step(1, d, 0);
        k = cyc;
        repeat (FRAME + 8) begin
            step(0, '0, 0);
            n_cmp++;
            if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== exp_vec(cyc)) begin
                n_fail++;
                $display("FAIL %s_cycle cyc=%0d got=%b exp=%b", name, cyc, {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, exp_vec(cyc));
            end
        end
        n_cmp++;
        if (rx_falls.size() != 1 || rx_falls[0] - k != 2) begin
            n_fail++;
            $display("FAIL %s_latency falls=%0d fall_after=%0d exp=2", name, rx_falls.size(), rx_falls[0] - k);
        end
        n_cmp++;
        if (read_cyc.size() != 1 || rx_falls.size() != 1 || read_cyc[0] - rx_falls[0] != FRAME) begin
            n_fail++;
            $display("FAIL %s_read pulses=%0d delay=%0d exp 1 pulse at %0d", name, read_cyc.size(), read_cyc[0] - rx_falls[0], FRAME);
        end
        n_cmp++;
        if (rx_bytes.size() != 1 || rx_bytes[0] !== d[7:0] || rx_bad_stop != 0) begin
            n_fail++;
            $display("FAIL %s_byte got=%h n=%0d bad_stop=%0d exp=%h", name, rx_bytes[0], rx_bytes.size(), rx_bad_stop, d[7:0]);
        end
        n_cmp++;
        if (tx_busy !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle busy=%b ovf=%b exp 0 0", name, tx_busy, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  bl [5];
        logic [31:0] d;
        bl = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        step(0, '0, 1);
        step(0, '0, 1);
        for (int i = 0; i < 5; i++) begin
            d = $urandom();
            d[7:0] = bl[i];
            step(1, d, 0);
            n_cmp++;
            if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== exp_vec(cyc)) begin
                n_fail++;
                $display("FAIL burst_fill cyc=%0d got=%b exp=%b", cyc, {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, exp_vec(cyc));
            end
        end
        n_cmp++;
        if (fifo_count !== 3'd4 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL burst_count got=%0d ovf=%b exp=4 0", fifo_count, overflow);
        end
        repeat (5 * FRAME + 10) begin
            step(0, '0, 0);
            n_cmp++;
            if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== exp_vec(cyc)) begin
                n_fail++;
                $display("FAIL burst_cycle cyc=%0d got=%b exp=%b", cyc, {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, exp_vec(cyc));
            end
        end
        n_cmp++;
        if (read_cyc.size() != 5 || rx_bytes.size() != 5 || rx_bad_stop != 0) begin
            n_fail++;
            $display("FAIL burst_frames pulses=%0d bytes=%0d bad_stop=%0d exp 5 5 0", read_cyc.size(), rx_bytes.size(), rx_bad_stop);
        end
        for (int i = 0; i < 5 && i < rx_bytes.size(); i++) begin
            n_cmp++;
            if (rx_bytes[i] !== bl[i]) begin
                n_fail++;
                $display("FAIL burst_byte%0d got=%h exp=%h", i, rx_bytes[i], bl[i]);
            end
        end
        for (int i = 1; i < rx_falls.size(); i++) begin
            n_cmp++;
            if (rx_falls[i] - rx_falls[i-1] != FRAME) begin
                n_fail++;
                $display("FAIL burst_gap%0d got=%0d exp=%0d", i, rx_falls[i] - rx_falls[i-1], FRAME);
            end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        step(0, '0, 1);
        step(0, '0, 1);
        for (int i = 0; i < 5; i++) begin
            d = $urandom();
            d[7:0] = 8'hA0 + 8'(i);
            step(1, d, 0);
        end
        n_cmp++;
        if (tx_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_ready got=%b exp=0", tx_ready);
        end
        step(1, 32'h0000_0099, 0);
        n_cmp++;
        if (overflow !== 1'b1 || fifo_count !== 3'd4) begin
            n_fail++;
            $display("FAIL ovf_set ovf=%b count=%0d exp 1 4", overflow, fifo_count);
        end
        repeat (5 * FRAME + 10) begin
            step(0, '0, 0);
            n_cmp++;
            if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== exp_vec(cyc)) begin
                n_fail++;
                $display("FAIL ovf_cycle cyc=%0d got=%b exp=%b", cyc, {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, exp_vec(cyc));
            end
        end
        n_cmp++;
        if (rx_bytes.size() != 5 || read_cyc.size() != 5) begin
            n_fail++;
            $display("FAIL ovf_frames bytes=%0d pulses=%0d exp 5 5", rx_bytes.size(), read_cyc.size());
        end
        for (int i = 0; i < rx_bytes.size(); i++) begin
            n_cmp++;
            if (rx_bytes[i] !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("FAIL ovf_byte%0d got=%h exp=%h", i, rx_bytes[i], 8'hA0 + 8'(i));
            end
        end
        n_cmp++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky got=%b exp=1", overflow);
        end
        step(0, '0, 1);
        n_cmp++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear got=%b exp=0", overflow);
        end
    endtask

    task automatic test_reset_midframe();
        step(0, '0, 1);
        step(0, '0, 1);
        step(1, 32'h0000_00F0, 0);
        repeat (17) step(0, '0, 0);
        step(0, '0, 1);
        n_cmp++;
        if (tx !== 1'b1 || fifo_count !== 3'd0 || tx_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_state tx=%b count=%0d busy=%b exp 1 0 0", tx, fifo_count, tx_busy);
        end
        repeat (FRAME + 10) begin
            step(0, '0, 0);
            n_cmp++;
            if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== exp_vec(cyc)) begin
                n_fail++;
                $display("FAIL midrst_cycle cyc=%0d got=%b exp=%b", cyc, {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, exp_vec(cyc));
            end
        end
        n_cmp++;
        if (read_cyc.size() != 0) begin
            n_fail++;
            $display("FAIL midrst_no_read pulses=%0d exp=0", read_cyc.size());
        end
        test_single_frame(32'h0000_000F, 1'b0, "midrst_after");
    endtask

    task automatic test_random();
        int gap;
        step(0, '0, 1);
        step(0, '0, 1);
        repeat (40) begin
            gap = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 50));
            repeat (gap) begin
                step(0, '0, 0);
                n_cmp++;
                if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== exp_vec(cyc)) begin
                    n_fail++;
                    $display("FAIL rand_cycle cyc=%0d got=%b exp=%b", cyc, {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, exp_vec(cyc));
                end
            end
            step(1, $urandom(), 0);
            n_cmp++;
            if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== exp_vec(cyc)) begin
                n_fail++;
                $display("FAIL rand_write cyc=%0d got=%b exp=%b", cyc, {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, exp_vec(cyc));
            end
        end
        repeat ((DEPTH + 2) * FRAME) begin
            step(0, '0, 0);
            n_cmp++;
            if ({tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count} !== exp_vec(cyc)) begin
                n_fail++;
                $display("FAIL rand_drain cyc=%0d got=%b exp=%b", cyc, {tx, mmio_read, tx_ready, tx_busy, overflow, fifo_count}, exp_vec(cyc));
            end
        end
        n_cmp++;
        if (rx_bytes.size() != m_byte.size() || read_cyc.size() != m_byte.size() || rx_bad_stop != 0) begin
            n_fail++;
            $display("FAIL rand_frames bytes=%0d pulses=%0d bad_stop=%0d exp=%0d", rx_bytes.size(), read_cyc.size(), rx_bad_stop, m_byte.size());
        end
        for (int i = 0; i < rx_bytes.size() && i < m_byte.size(); i++) begin
            n_cmp++;
            if (rx_bytes[i] !== m_byte[i]) begin
                n_fail++;
                $display("FAIL rand_byte%0d got=%h exp=%h", i, rx_bytes[i], m_byte[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(32'h0000_00A5, 1'b1, "single_a5");
        test_single_frame(32'hFFFF_FF3C, 1'b1, "upper_bits");
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_mmio_tx.md
Name: uart_mmio_tx

Overview:
- Memory-mapped UART transmitter for the core's MMIO store path: byte writes become 8N1 serial frames on `tx`.
- It is the transmit-side counterpart of the UART programmer receiver.
- A small FIFO decouples core stores from the baud rate. The core never stalls; software polls `tx_ready`.
- `mmio_read` pulses once per completed frame.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); legal range >= 2.
- FIFO_DEPTH, 16, transmit FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  system clock
- Rst  input  1  reset; synchronous, active-high
- mmio_wea  input  1  one-cycle write strobe from the memory stage
- mmio_dat  input  32  store data; only [7:0] is transmitted, [31:8] ignored
- tx  output  1  serial line; idle high
- mmio_read  output  1  one-cycle pulse when a frame's stop bit completes
- tx_ready  output  1  FIFO not full; a write is accepted this cycle
- tx_busy  output  1  FSM not IDLE, or FIFO not empty
- fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  output  1  sticky flag: a write was dropped because the FIFO was full

Behaviour:
- Reset (synchronous, takes priority over everything):
  - tx=1, mmio_read=0, tx_ready=1, tx_busy=0, fifo_count=0, overflow=0.
  - FIFO pointers cleared; FSM returns to IDLE.
  - Reset mid-frame aborts the frame; tx is high on the cycle after the reset edge.
- FIFO write:
  - mmio_wea=1 and fifo_count<FIFO_DEPTH: mmio_dat[7:0] is pushed at that edge.
  - mmio_wea=1 and the FIFO is full: the data is dropped and overflow is set.
  - A full FIFO rejects the write even if a pop occurs in the same cycle.
- FIFO pop:
  - Happens only when the FSM loads a byte.
  - Push and pop in the same cycle leave fifo_count unchanged.
- All outputs are registered except tx_ready and tx_busy, which are combinational from registered state.
- FSM states: IDLE, START, DATA, STOP.
- Baud counter runs 0..CLKS_PER_BIT-1. A bit ends when the counter reaches CLKS_PER_BIT-1.
- IDLE:
  - tx=1.
  - If the FIFO is non-empty: pop into an 8-bit shift register, clear the baud counter, go to START.
- START:
  - tx=0 for CLKS_PER_BIT cycles, then go to DATA with the bit index at 0.
- DATA:
  - tx = shift[0] (LSB first) for CLKS_PER_BIT cycles per bit.
  - Shift right at each bit end.
  - After bit index 7 completes, go to STOP.
- STOP:
  - tx=1 for CLKS_PER_BIT cycles.
  - At the last stop cycle, assert mmio_read for exactly one cycle.
  - If the FIFO is non-empty: pop and go directly to START (back-to-back frames, no idle gap).
  - Otherwise go to IDLE.
- Latency: with the FIFO empty and FSM in IDLE, a write accepted at edge k makes tx fall after edge k+2.
- Frame timing: frame length is exactly 10*CLKS_PER_BIT cycles. The mmio_read pulse occurs 10*CLKS_PER_BIT cycles after tx falls.
- Counter widths:
  - baud counter: $clog2(CLKS_PER_BIT).
  - bit index: 3 bits.
  - FIFO pointers: $clog2(FIFO_DEPTH), wrapping modulo FIFO_DEPTH.
- overflow clears only on Rst.

Decomposition:
- Package uart_pkg holds:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_tx_state_t
  - UART_DATA_BITS=8
  - default baud constant UART_CLKS_PER_BIT=434
- Sub-module uart_tx_fifo (synchronous FWFT FIFO, params WIDTH=8, DEPTH):
  - Inputs: push, pop, din.
  - Outputs: dout, full, empty, count.
- The top level holds the FSM, baud counter, shift register and overflow logic.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Reset then idle 50 cycles -> tx=1 throughout; tx_ready=1, tx_busy=0, fifo_count=0, mmio_read never pulses.
2. Single write mmio_dat=0x0000_00A5 at edge k:
   - tx falls after edge k+2.
   - Sampled bits at 4-cycle intervals are 0 | 1,0,1,0,0,1,0,1 | 1.
   - mmio_read pulses once, 40 cycles after tx fall.
   - tx_busy=0 afterwards.
3. Upper bits ignored: write 0xFFFF_FF3C -> transmitted byte is 0x3C; no overflow.
4. Burst of 5 writes 0x11,0x22,0x33,0x44,0x55 on consecutive cycles:
   - First write popped after 1 cycle, remaining 4 fill the FIFO; no drop, overflow=0.
   - All five bytes are sent back-to-back, no high gap between a stop bit and the next start bit.
   - 5 mmio_read pulses.
5. Overflow:
   - Fill the FIFO (4 entries plus 1 in flight), then write 0x99 -> tx_ready=0 at that cycle, 0x99 never transmitted, overflow=1 and stays 1.
   - A second Rst clears it.
6. Reset mid-frame: write 0xF0, assert Rst during DATA bit 3:
   - tx=1 next cycle, fifo_count=0, no mmio_read pulse.
   - A subsequent write 0x0F transmits a clean frame.
